// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the pipelined MIPS control unit.
//   - opcode / funct encodings decoded in the Decode stage
//   - ALU operation codes (4-bit canonical form, resized at the top level)
//   - per-stage control bundles: the EX bundle nests the MEM bundle, which
//     nests the WB bundle, so each stage register simply forwards the
//     sub-struct the next stage needs.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_NOP = 6'b000000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_NOR = 4'b0100;
  localparam logic [3:0] ALU_LUI = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  typedef struct packed {
    logic     memwrite;
    wb_ctrl_t wb;
  } mem_ctrl_t;

  typedef struct packed {
    logic      alusrc;
    logic      regdst;
    logic [3:0] alu;
    mem_ctrl_t mem;
  } ex_ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational opcode/funct decoder.
// Ports:
//   op, funct  : instruction[31:26] / instruction[5:0] in Decode
//   ctrl       : control bundle to be carried through EX/MEM/WB
//   branch     : beq or bne
//   bne        : branch condition is inverted (bne)
//   jump       : j
//   zeroext    : immediate is zero-extended (logical immediates, lui)
//   illegal    : unrecognised encoding; every other output forced to 0
// EXT_OPS=0 treats andi/ori/xori/lui/bne and R-type xor/nor as illegal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter bit EXT_OPS = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ex_ctrl_t   ctrl,
  output logic       branch,
  output logic       bne,
  output logic       jump,
  output logic       zeroext,
  output logic       illegal
);

  always_comb begin
    ctrl    = '0;
    branch  = 1'b0;
    bne     = 1'b0;
    jump    = 1'b0;
    zeroext = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        // funct 0 is the canonical NOP: everything stays zero, not illegal
        if (funct != F_NOP) begin
          ctrl.mem.wb.regwrite = 1'b1;
          ctrl.regdst          = 1'b1;
          case (funct)
            F_ADD:   ctrl.alu = ALU_ADD;
            F_SUB:   ctrl.alu = ALU_SUB;
            F_AND:   ctrl.alu = ALU_AND;
            F_OR:    ctrl.alu = ALU_OR;
            F_SLT:   ctrl.alu = ALU_SLT;
            F_XOR:   if (EXT_OPS) ctrl.alu = ALU_XOR; else illegal = 1'b1;
            F_NOR:   if (EXT_OPS) ctrl.alu = ALU_NOR; else illegal = 1'b1;
            default: illegal = 1'b1;
          endcase
        end
      end
      OP_LW: begin
        ctrl.mem.wb.regwrite = 1'b1;
        ctrl.mem.wb.memtoreg = 1'b1;
        ctrl.alusrc          = 1'b1;
        ctrl.alu             = ALU_ADD;
      end
      OP_SW: begin
        ctrl.mem.memwrite = 1'b1;
        ctrl.alusrc       = 1'b1;
        ctrl.alu          = ALU_ADD;
      end
      OP_BEQ: begin
        branch   = 1'b1;
        ctrl.alu = ALU_SUB;
      end
      OP_BNE: begin
        if (EXT_OPS) begin
          branch   = 1'b1;
          bne      = 1'b1;
          ctrl.alu = ALU_SUB;
        end else illegal = 1'b1;
      end
      OP_ADDI, OP_SLTI: begin
        ctrl.mem.wb.regwrite = 1'b1;
        ctrl.alusrc          = 1'b1;
        ctrl.alu             = (op == OP_ADDI) ? ALU_ADD : ALU_SLT;
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        if (EXT_OPS) begin
          ctrl.mem.wb.regwrite = 1'b1;
          ctrl.alusrc          = 1'b1;
          zeroext              = 1'b1;
          case (op)
            OP_ANDI: ctrl.alu = ALU_AND;
            OP_ORI:  ctrl.alu = ALU_OR;
            OP_XORI: ctrl.alu = ALU_XOR;
            default: ctrl.alu = ALU_LUI;
          endcase
        end else illegal = 1'b1;
      end
      OP_J:    jump    = 1'b1;
      default: illegal = 1'b1;
    endcase

    // an illegal encoding must not leak any partial control
    if (illegal) begin
      ctrl    = '0;
      branch  = 1'b0;
      bne     = 1'b0;
      jump    = 1'b0;
      zeroext = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller: control unit for the five-stage MIPS core.
// Decodes in D (combinational), then carries control through the EX, MEM
// and WB stage registers under hazard-unit stall/flush.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   opD, functD, equalD       : Decode-stage instruction fields, rs==rt
//   stallE, flushE, flushM    : hazard controls (hold EX, bubble EX/MEM)
//   pcsrcD, branchD, jumpD, zeroextD, illegalD : Decode controls
//   regwriteE .. alucontrolE  : EX register
//   regwriteM, memtoregM, memwriteM : MEM register
//   regwriteW, memtoregW      : WB register
// ALUCTRL_W must be >=4 with EXT_OPS=1 and >=3 otherwise.
module pipe_controller
  import ctrl_pkg::*;
#(
  parameter int ALUCTRL_W = 4,
  parameter bit EXT_OPS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opD,
  input  logic [5:0]           functD,
  input  logic                 equalD,
  input  logic                 stallE,
  input  logic                 flushE,
  input  logic                 flushM,
  output logic                 pcsrcD,
  output logic                 branchD,
  output logic                 jumpD,
  output logic                 zeroextD,
  output logic                 illegalD,
  output logic                 regwriteE,
  output logic                 memtoregE,
  output logic                 memwriteE,
  output logic                 alusrcE,
  output logic                 regdstE,
  output logic [ALUCTRL_W-1:0] alucontrolE,
  output logic                 regwriteM,
  output logic                 memtoregM,
  output logic                 memwriteM,
  output logic                 regwriteW,
  output logic                 memtoregW
);

  ex_ctrl_t  ctrl_p0;
  ex_ctrl_t  ctrl_p1;
  mem_ctrl_t ctrl_p2;
  wb_ctrl_t  ctrl_p3;
  logic      bne_p0;

  // ---- Decode (p0): combinational ----
  ctrl_decode #(.EXT_OPS(EXT_OPS)) u_decode (
    .op      (opD),
    .funct   (functD),
    .ctrl    (ctrl_p0),
    .branch  (branchD),
    .bne     (bne_p0),
    .jump    (jumpD),
    .zeroext (zeroextD),
    .illegal (illegalD)
  );

  assign pcsrcD = branchD & (equalD ^ bne_p0);

  // ---- D -> EX (p1): flush beats stall ----
  always_ff @(posedge clk) begin
    if (rst || flushE)  ctrl_p1 <= '0;
    else if (!stallE)   ctrl_p1 <= ctrl_p0;
  end

  // ---- EX -> MEM (p2): bubble while EX is held so nothing issues twice ----
  always_ff @(posedge clk) begin
    if (rst || flushM || stallE) ctrl_p2 <= '0;
    else                         ctrl_p2 <= ctrl_p1.mem;
  end

  // ---- MEM -> WB (p3): never stalls ----
  always_ff @(posedge clk) begin
    if (rst) ctrl_p3 <= '0;
    else     ctrl_p3 <= ctrl_p2.wb;
  end

  assign regwriteE   = ctrl_p1.mem.wb.regwrite;
  assign memtoregE   = ctrl_p1.mem.wb.memtoreg;
  assign memwriteE   = ctrl_p1.mem.memwrite;
  assign alusrcE     = ctrl_p1.alusrc;
  assign regdstE     = ctrl_p1.regdst;
  assign alucontrolE = ALUCTRL_W'(ctrl_p1.alu);
  assign regwriteM   = ctrl_p2.wb.regwrite;
  assign memtoregM   = ctrl_p2.wb.memtoreg;
  assign memwriteM   = ctrl_p2.memwrite;
  assign regwriteW   = ctrl_p3.regwrite;
  assign memtoregW   = ctrl_p3.memtoreg;

endmodule

// File: doc/pipe_controller.md
# pipe_controller

Pipelined control unit for the five-stage MIPS core. Decodes opcode/funct in the Decode stage, resolves branch/jump selection there, and carries the remaining control bits through the EX, MEM and WB pipeline registers with hazard-driven stall and flush. Parametrised ALU-control width and an optional extended instruction subset. It pairs with the hazard unit, which drives the stall and flush inputs and reads the E/M-stage regwrite/memtoreg outputs.

## Interface
- ALUCTRL_W, 4: width of alucontrol; must be ≥4 when EXT_OPS=1, ≥3 otherwise.
- EXT_OPS, 1: 1 enables andi/ori/xori/lui/bne/nor; 0 decodes them as illegal.
- clk  input  1  core clock, all registers on rising edge.
- rst  input  1  reset; synchronous, active-high.
- opD  input  6  instruction[31:26] in Decode.
- functD  input  6  instruction[5:0] in Decode.
- equalD  input  1  rs==rt comparison from the Decode datapath.
- stallE  input  1  hold the EX register (multi-cycle EX op).
- flushE  input  1  bubble into EX.
- flushM  input  1  bubble into MEM.
- pcsrcD, branchD, jumpD, zeroextD, illegalD  output  1 each  combinational Decode controls.
- regwriteE, memtoregE, memwriteE, alusrcE, regdstE  output  1 each  EX register.
- alucontrolE  output  ALUCTRL_W  EX register.
- regwriteM, memtoregM, memwriteM  output  1 each  MEM register.
- regwriteW, memtoregW  output  1 each  WB register.

## Operation
- ALU codes (zero-extended to ALUCTRL_W): AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, LUI 0101, SUB 0110, SLT 0111.
- R-type (op 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 100110 xor*, 100111 nor*, 101010 slt → regwrite=1, regdst=1. (* EXT_OPS only.)
- op=0, funct=0 is NOP: all controls 0, illegalD=0.
- lw 100011: regwrite, alusrc, memtoreg, ADD. sw 101011: memwrite, alusrc, ADD.
- beq 000100: branchD, SUB; pcsrcD=equalD. bne 000101*: branchD, SUB; pcsrcD=~equalD.
- addi 001000 ADD, slti 001010 SLT: regwrite, alusrc, sign-extend.
- andi 001100, ori 001101, xori 001110, lui 001111*: regwrite, alusrc, zeroextD=1, respective ALU code.
- j 000010: jumpD=1, nothing else.
- Any other op/funct (or disabled EXT_OPS encoding): all controls 0, illegalD=1.
- pcsrcD is 0 for every non-branch op regardless of equalD.

## Timing
- Decode outputs: combinational, zero latency from opD/functD/equalD.
- EX register update priority: rst → all 0; flushE → all 0; stallE → hold; else load decoded values.
- MEM register: rst → 0; flushM → 0; stallE → 0 (bubble behind held EX); else load EX values.
- WB register: rst → 0; else load MEM values every cycle (never stalls).
- Latency: decoded control appears at E one cycle after D, M two, W three (no stalls).
- flushE with stallE same cycle: flush wins, EX becomes bubble.
- Reset mid-pipeline: all E/M/W outputs 0 on the next edge; no in-flight write survives.
- Reset values of every registered output: 0.

## Structure
- Package ctrl_pkg: opcode/funct localparams, ALU code localparams, a packed struct for the per-stage control bundle.
- One sub-module: ctrl_decode (pure combinational op/funct → bundle + illegal); pipe_controller holds the three stage registers and pcsrc logic.

## Test plan
- lw (op 100011) in D, no hazards → regwriteE/memtoregE/alusrcE=1, alucontrolE=0010 at +1; memtoregM at +2; regwriteW=1, memtoregW=1 at +3.
- beq with equalD=1 then 0; bne with equalD=0 → pcsrcD 1, 0, 1; j gives jumpD=1, pcsrcD=0.
- addi held in D under stallE=1 for 2 cycles, R-type sub presented afterwards → EX holds addi (alucontrolE=0010) during stall, MEM shows bubbles (regwriteM=0), then sub (0110) enters EX.
- flushE=1 and stallE=1 same cycle with sw in EX → memwriteE=0 next cycle.
- EXT_OPS=0: ori (001101) → illegalD=1, all outputs 0; EXT_OPS=1: ori → zeroextD=1, alucontrolE=0001. op=0/funct=0 → illegalD=0, all zero.
- rst asserted while sw in MEM and lw in WB → memwriteM, regwriteW, memtoregW all 0 after next edge.
